// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// master = datapath side (drives hazard sources); slave = sequencer (drives stall/flush).
interface pipeline_hazard_ctrl_if;
  logic [4:0]  i_rs1_d;
  logic [4:0]  i_rs2_d;
  logic        i_rs1_used_d;
  logic        i_rs2_used_d;
  logic [4:0]  i_rd_e;
  logic        i_mem_read_e;
  logic        i_ex_busy_e;
  logic        i_redirect_e;
  logic        i_exception_valid_m;

  logic        o_pc_stall;
  logic        o_pc_sel_trap;
  logic        o_if_id_stall;
  logic        o_if_id_flush;
  logic        o_id_ex_stall;
  logic        o_id_ex_flush;
  logic        o_ex_mem_flush;
  logic [1:0]  o_state;
  logic [15:0] o_stall_cycles;

  modport master (
    output i_rs1_d, i_rs2_d, i_rs1_used_d, i_rs2_used_d, i_rd_e,
           i_mem_read_e, i_ex_busy_e, i_redirect_e, i_exception_valid_m,
    input  o_pc_stall, o_pc_sel_trap, o_if_id_stall, o_if_id_flush,
           o_id_ex_stall, o_id_ex_flush, o_ex_mem_flush, o_state, o_stall_cycles
  );

  modport slave (
    input  i_rs1_d, i_rs2_d, i_rs1_used_d, i_rs2_used_d, i_rd_e,
           i_mem_read_e, i_ex_busy_e, i_redirect_e, i_exception_valid_m,
    output o_pc_stall, o_pc_sel_trap, o_if_id_stall, o_if_id_flush,
           o_id_ex_stall, o_id_ex_flush, o_ex_mem_flush, o_state, o_stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: zero-cycle hazard answers, drain-then-redirect trap entry.
// Stalls are the backpressure: PC/IF-ID/ID-EX hold while a hazard or trap drain is in progress.
module pipeline_hazard_ctrl #(
  parameter int unsigned TRAP_DRAIN_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clk_en,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_DRAIN    = 2'b01,
    ST_REDIRECT = 2'b10
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(TRAP_DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q;
  logic        load_use;

  logic pc_stall, pc_sel_trap, if_id_stall, if_id_flush;
  logic id_ex_stall, id_ex_flush, ex_mem_flush;

  assign load_use = hz.i_mem_read_e && (hz.i_rd_e != 5'd0) &&
                    ((hz.i_rs1_used_d && (hz.i_rs1_d == hz.i_rd_e)) ||
                     (hz.i_rs2_used_d && (hz.i_rs2_d == hz.i_rd_e)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    pc_sel_trap  = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.i_exception_valid_m) begin
          ex_mem_flush = 1'b1;
          id_ex_flush  = 1'b1;
          if_id_flush  = 1'b1;
          pc_stall     = 1'b1;
          state_d      = ST_DRAIN;
          cnt_d        = DRAIN_LOAD;
        end else if (hz.i_ex_busy_e) begin
          // Redirect is not final until the multi-cycle op completes, so it is ignored here.
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (hz.i_redirect_e) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_flush  = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_REDIRECT: begin
        pc_sel_trap = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      stall_q <= 16'd0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  // Outputs are forced low for the whole reset assertion, not just at the next edge.
  assign hz.o_pc_stall     = i_rst_n & pc_stall;
  assign hz.o_pc_sel_trap  = i_rst_n & pc_sel_trap;
  assign hz.o_if_id_stall  = i_rst_n & if_id_stall;
  assign hz.o_if_id_flush  = i_rst_n & if_id_flush;
  assign hz.o_id_ex_stall  = i_rst_n & id_ex_stall;
  assign hz.o_id_ex_flush  = i_rst_n & id_ex_flush;
  assign hz.o_ex_mem_flush = i_rst_n & ex_mem_flush;
  assign hz.o_state        = state_q;
  assign hz.o_stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: trap-position reference model checked every cycle plus directed literal checks.
module tb_pipeline_hazard_ctrl;
  localparam int T = 2;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_clk_en = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.TRAP_DRAIN_CYCLES(T)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clk_en(i_clk_en),
    .hz      (hif.slave)
  );

  always #5 i_clk = ~i_clk;

  // Output vector layout: {pc_stall, pc_sel_trap, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, state[1:0]}
  logic [8:0] dut_vec;
  assign dut_vec = {hif.o_pc_stall, hif.o_pc_sel_trap, hif.o_if_id_stall, hif.o_if_id_flush,
                    hif.o_id_ex_stall, hif.o_id_ex_flush, hif.o_ex_mem_flush, hif.o_state};

  // Reference model: trap_pos 0 = no trap, 1..T = draining, T+1 = redirect cycle.
  int         trap_pos;
  int         model_stalls;
  logic [8:0] model_vec;
  logic       m_hazard;

  always_comb begin
    model_vec = 9'd0;
    m_hazard  = hif.i_mem_read_e && (hif.i_rd_e != 5'd0) &&
                ((hif.i_rs1_used_d && hif.i_rs1_d == hif.i_rd_e) ||
                 (hif.i_rs2_used_d && hif.i_rs2_d == hif.i_rd_e));
    if (!i_rst_n)                    model_vec = 9'b0_0_0_0_0_0_0_00;
    else if (trap_pos > T)           model_vec = 9'b0_1_0_1_0_1_0_10;
    else if (trap_pos >= 1)          model_vec = 9'b1_0_0_1_0_1_1_01;
    else if (hif.i_exception_valid_m) model_vec = 9'b1_0_0_1_0_1_1_00;
    else if (hif.i_ex_busy_e)        model_vec = 9'b1_0_1_0_1_0_1_00;
    else if (hif.i_redirect_e)       model_vec = 9'b0_0_0_1_0_1_0_00;
    else if (m_hazard)               model_vec = 9'b1_0_1_0_0_1_0_00;
  end

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trap_pos     <= 0;
      model_stalls <= 0;
    end else if (i_clk_en) begin
      if (model_vec[8]) model_stalls <= (model_stalls >= 65535) ? 65535 : model_stalls + 1;
      if (trap_pos == 0)          trap_pos <= hif.i_exception_valid_m ? 1 : 0;
      else if (trap_pos == T + 1) trap_pos <= 0;
      else                        trap_pos <= trap_pos + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    chk("model_outputs", {23'd0, dut_vec}, {23'd0, model_vec});
    chk("model_stall_cycles", {16'd0, hif.o_stall_cycles}, model_stalls);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.i_rs1_d = 5'd0; hif.i_rs2_d = 5'd0;
    hif.i_rs1_used_d = 1'b0; hif.i_rs2_used_d = 1'b0;
    hif.i_rd_e = 5'd0; hif.i_mem_read_e = 1'b0;
    hif.i_ex_busy_e = 1'b0; hif.i_redirect_e = 1'b0;
    hif.i_exception_valid_m = 1'b0;
  endtask

  task automatic pulse_reset();
    step();
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    #2;
    chk("reset_outputs", {23'd0, dut_vec}, 32'd0);
    chk("reset_stall_cycles", {16'd0, hif.o_stall_cycles}, 32'd0);
    repeat (2) step();
    i_rst_n = 1'b1;

    // Load-use on rs1
    step();
    hif.i_mem_read_e = 1'b1; hif.i_rd_e = 5'd5; hif.i_rs1_d = 5'd5; hif.i_rs1_used_d = 1'b1;
    #1;
    chk("loaduse_vec", {23'd0, dut_vec}, {23'd0, 9'b1_0_1_0_0_1_0_00});
    step();
    hif.i_rd_e = 5'd0; hif.i_rs1_d = 5'd0;
    #1;
    chk("loaduse_rd0", {23'd0, dut_vec}, 32'd0);
    step();
    hif.i_rd_e = 5'd5; hif.i_rs1_d = 5'd5; hif.i_rs1_used_d = 1'b0;
    #1;
    chk("loaduse_unused_pc_stall", {31'd0, hif.o_pc_stall}, 32'd0);
    step();
    hif.i_rs2_d = 5'd5; hif.i_rs2_used_d = 1'b1;
    #1;
    chk("loaduse_rs2_pc_stall", {31'd0, hif.o_pc_stall}, 32'd1);

    // Redirect over load-use; busy over redirect
    step();
    hif.i_redirect_e = 1'b1;
    #1;
    chk("redirect_over_loaduse", {23'd0, dut_vec}, {23'd0, 9'b0_0_0_1_0_1_0_00});
    step();
    hif.i_ex_busy_e = 1'b1;
    #1;
    chk("busy_over_redirect", {23'd0, dut_vec}, {23'd0, 9'b1_0_1_0_1_0_1_00});
    chk("busy_no_if_id_flush", {31'd0, hif.o_if_id_flush}, 32'd0);

    // Single exception from a clean counter
    step();
    clear_inputs();
    pulse_reset();
    step();
    hif.i_exception_valid_m = 1'b1;
    #1;
    chk("exc_c0_vec", {23'd0, dut_vec}, {23'd0, 9'b1_0_0_1_0_1_1_00});
    step();
    hif.i_exception_valid_m = 1'b0;
    #1;
    chk("exc_c1_state", {30'd0, hif.o_state}, 32'd1);
    chk("exc_c1_sel_trap", {31'd0, hif.o_pc_sel_trap}, 32'd0);
    step(); #1;
    chk("exc_c2_state", {30'd0, hif.o_state}, 32'd1);
    step(); #1;
    chk("exc_c3_state", {30'd0, hif.o_state}, 32'd2);
    chk("exc_c3_sel_trap", {31'd0, hif.o_pc_sel_trap}, 32'd1);
    chk("exc_c3_pc_stall", {31'd0, hif.o_pc_stall}, 32'd0);
    step(); #1;
    chk("exc_c4_state", {30'd0, hif.o_state}, 32'd0);
    chk("exc_c4_sel_trap", {31'd0, hif.o_pc_sel_trap}, 32'd0);
    chk("exc_stall_delta", {16'd0, hif.o_stall_cycles}, 32'd3);

    // Exception held through DRAIN with clock enable dropped for 4 cycles
    step();
    hif.i_exception_valid_m = 1'b1;
    step();
    i_clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_frozen_state", {30'd0, hif.o_state}, 32'd1);
      step();
    end
    i_clk_en = 1'b1;
    #1;
    chk("drain_resume_state", {30'd0, hif.o_state}, 32'd1);
    step(); #1;
    chk("drain_last_state", {30'd0, hif.o_state}, 32'd1);
    step(); #1;
    chk("drain_no_restart", {30'd0, hif.o_state}, 32'd2);
    hif.i_exception_valid_m = 1'b0;
    step(); #1;
    chk("drain_back_to_run", {30'd0, hif.o_state}, 32'd0);
    chk("drain_stall_total", {16'd0, hif.o_stall_cycles}, 32'd6);

    // Asynchronous reset while draining
    step();
    hif.i_exception_valid_m = 1'b1;
    step();
    hif.i_exception_valid_m = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, hif.o_state}, 32'd0);
    chk("async_rst_outputs", {23'd0, dut_vec}, 32'd0);
    chk("async_rst_stall_cycles", {16'd0, hif.o_stall_cycles}, 32'd0);
    step();
    i_rst_n = 1'b1;

    // Saturation of the perf counter
    step();
    hif.i_ex_busy_e = 1'b1;
    repeat (70000) step();
    #1;
    chk("stall_saturated", {16'd0, hif.o_stall_cycles}, 32'h0000FFFF);
    chk("sat_pc_stall", {31'd0, hif.o_pc_stall}, 32'd1);
    step();
    clear_inputs();
    step(); #1;
    chk("sat_no_wrap", {16'd0, hif.o_stall_cycles}, 32'h0000FFFF);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register. It resolves load-use hazards, multi-cycle EX occupancy, EX branch/jump redirects and MEM-stage exception entry. Exception entry runs as a drain-then-redirect state machine, and a saturating perf counter records stalled fetch cycles.

## Interface
- TRAP_DRAIN_CYCLES, default 2 — number of DRAIN cycles after exception acceptance, legal range 1..15.
- i_clk  input  1  — pipeline clock, rising edge.
- i_rst_n  input  1  — reset, asynchronous, active-low.
- i_clk_en  input  1  — global clock enable; when low, state, counter and perf counter hold.
- i_rs1_d, i_rs2_d  input  5 each  — source registers of the instruction in ID.
- i_rs1_used_d, i_rs2_used_d  input  1 each  — the source operand is actually read.
- i_rd_e  input  5  — destination register of the instruction in EX.
- i_mem_read_e  input  1  — the instruction in EX is a load.
- i_ex_busy_e  input  1  — the multi-cycle unit (mul/div) in EX has not finished.
- i_redirect_e  input  1  — a taken branch, jump or mispredict is resolved in EX.
- i_exception_valid_m  input  1  — a valid exception is signalled from MEM.
- o_pc_stall  output  1  — hold the PC.
- o_pc_sel_trap  output  1  — the PC loads the trap vector this cycle.
- o_if_id_stall, o_if_id_flush  output  1 each.
- o_id_ex_stall, o_id_ex_flush  output  1 each.
- o_ex_mem_flush  output  1.
- o_state  output  2  — 00 RUN, 01 DRAIN, 10 REDIRECT.
- o_stall_cycles  output  16  — saturating count of cycles in which o_pc_stall is high.

## Operation
- FSM state and the drain counter are registered. All stall/flush outputs are combinational from the state and the current inputs, so a hazard is answered in the same cycle it appears.
- While i_rst_n is low:
  - state = RUN, counter = 0, o_stall_cycles = 0.
  - Every stall, flush and select output is forced to 0.
- RUN, events evaluated in fixed priority (highest first):
  1. i_exception_valid_m:
     - Assert o_ex_mem_flush, o_id_ex_flush, o_if_id_flush and o_pc_stall.
     - Next state DRAIN, counter loads TRAP_DRAIN_CYCLES-1.
  2. i_ex_busy_e:
     - Assert o_pc_stall, o_if_id_stall and o_id_ex_stall.
     - Assert o_ex_mem_flush to insert a bubble into MEM.
     - i_redirect_e is ignored while busy, because the redirect is not yet final.
  3. i_redirect_e:
     - Assert o_if_id_flush and o_id_ex_flush; no stall.
     - A simultaneous load-use hazard is suppressed, because the dependent instruction is being killed.
  4. Load-use hazard: i_mem_read_e && i_rd_e!=0 && ((i_rs1_used_d && i_rs1_d==i_rd_e) || (i_rs2_used_d && i_rs2_d==i_rd_e)).
     - Assert o_pc_stall and o_if_id_stall.
     - Assert o_id_ex_flush (bubble).
  5. Otherwise all outputs are 0.
- DRAIN:
  - o_pc_stall, o_if_id_flush, o_id_ex_flush and o_ex_mem_flush are all 1.
  - The counter decrements each enabled cycle; at counter==0 the next state is REDIRECT.
  - All other inputs, including a new exception, are ignored.
- REDIRECT:
  - o_pc_sel_trap = 1, o_if_id_flush = 1, o_id_ex_flush = 1, o_pc_stall = 0.
  - Unconditional return to RUN.
  - Inputs are ignored.
- Perf counter: o_stall_cycles increments when i_clk_en && o_pc_stall, and saturates at 0xFFFF.
- Only one of each stall/flush pair may be acted on per register. If both are high, the register gives flush precedence, and this block never drives both for the same register.

## Timing
- Hazard outputs have zero-cycle latency from their inputs.
- FSM transitions occur at the rising i_clk edge qualified by i_clk_en. With i_clk_en low, the state is frozen and the outputs reflect the frozen state.
- Exception sequence, with the exception accepted in cycle 0:
  - Cycle 0: flush all stages.
  - Cycles 1..TRAP_DRAIN_CYCLES: DRAIN.
  - Cycle TRAP_DRAIN_CYCLES+1: REDIRECT, PC = trap vector.
  - Cycle TRAP_DRAIN_CYCLES+2: RUN.
  - o_pc_stall is high for TRAP_DRAIN_CYCLES+1 cycles in total.
- Load-use stall lasts one cycle, because the load advances out of EX next cycle.
- A busy stall lasts as long as i_ex_busy_e is high.
- Asserting i_rst_n low mid-sequence returns to RUN immediately, without waiting for a clock edge.

## Test plan
- Load-use: i_mem_read_e=1, i_rd_e=5, i_rs1_d=5, i_rs1_used_d=1 -> the same cycle shows o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1; with i_rd_e=0 all outputs are 0; with i_rs1_used_d=0 no stall.
- Priority:
  - i_redirect_e=1 together with a load-use hazard -> o_if_id_flush=1, o_id_ex_flush=1, o_pc_stall=0.
  - i_ex_busy_e=1 together with i_redirect_e=1 -> stall pattern and o_ex_mem_flush=1, no o_if_id_flush.
- Exception with TRAP_DRAIN_CYCLES=2: pulse i_exception_valid_m for one cycle -> o_state goes 00,01,01,10,00. o_pc_sel_trap is high only in the 10 cycle. o_stall_cycles has advanced by exactly 3.
- Exception during DRAIN, plus i_clk_en held low for 4 cycles -> no restart of the sequence, and o_state holds 01 through the disabled cycles.
- Reset: drop i_rst_n while in DRAIN -> o_state=00, o_stall_cycles=0 and all outputs 0 before the next clock edge.
- Saturation: 70000 cycles with i_ex_busy_e=1 -> o_stall_cycles=0xFFFF, with no wrap.
